// File: rtl/seq_shift_pkg.sv
// Shared types and encodings for the sequential variable shifter.
package seq_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Same op encoding as the combinational SHIFTER cell.
    localparam logic OP_LEFT  = 1'b1;
    localparam logic OP_RIGHT = 1'b0;

endpackage

// File: rtl/seq_var_shifter_shift_step1.sv
// One-position shift of a WIDTH-bit word; the fill bit enters the vacated end.
module shift_step1
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             op,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        case (op)
            OP_LEFT:  result = {data[WIDTH-2:0], fill};
            OP_RIGHT: result = {fill, data[WIDTH-1:1]};
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/seq_var_shifter.sv
// Multi-cycle variable shifter: one bit position per clock, valid/ready on both sides.
module seq_var_shifter
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic             in_op,
    input  logic             in_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, sat_cnt;
    logic [WIDTH-1:0] data_r, data_nxt, step_data;
    logic             op_r, op_nxt;
    logic             val_r, val_nxt;

    shift_step1 #(.WIDTH(WIDTH)) u_step (
        .data   (data_r),
        .op     (op_r),
        .fill   (val_r),
        .result (step_data)
    );

    // Amounts of WIDTH or more all collapse to WIDTH steps: result is pure fill.
    always_comb begin
        if (32'(in_shift) >= 32'(WIDTH))
            sat_cnt = CW'(WIDTH);
        else
            sat_cnt = CW'(in_shift);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_r;
        op_nxt    = op_r;
        val_nxt   = val_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_nxt  = in_data;
                    op_nxt    = in_op;
                    val_nxt   = in_val;
                    cnt_nxt   = sat_cnt;
                    state_nxt = (sat_cnt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_nxt = step_data;
                cnt_nxt  = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            data_r <= '0;
            op_r   <= 1'b0;
            val_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_r <= data_nxt;
            op_r   <= op_nxt;
            val_r  <= val_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);
    assign out_data  = data_r;

endmodule

// File: tb/tb_seq_var_shifter.sv
// Scoreboard bench for seq_var_shifter: directed requests, decoupled output monitor.
module tb_seq_var_shifter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [3:0] in_shift = '0;
    logic       in_op = 1'b0;
    logic       in_val = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;

    seq_var_shifter #(.WIDTH(8), .SHW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_op     (in_op),
        .in_val    (in_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         acc;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every new result presentation pops one expectation.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        prev_valid = out_valid;
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] d, input logic [3:0] sh, input logic op,
                        input logic val, input logic [7:0] exp_data, input int exp_lat);
        exp_t e;
        int   t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_shift = sh;
        in_op    = op;
        in_val   = val;
        e.data = exp_data;
        e.acc  = cyc;
        e.lat  = exp_lat;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] held;

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Main function: left, right with fill, zero and saturated amounts
        send(8'hB5, 4'd3, 1'b1, 1'b0, 8'hA8, 4);
        check("busy_in_shift", 32'(busy), 32'd1);
        check("in_ready_in_shift", 32'(in_ready), 32'd0);
        drain();
        send(8'hB5, 4'd2, 1'b0, 1'b1, 8'hED, 3);
        drain();
        send(8'hB5, 4'd0, 1'b1, 1'b0, 8'hB5, 1);
        drain();
        send(8'hB5, 4'd12, 1'b1, 1'b1, 8'hFF, 9);
        drain();
        send(8'h5A, 4'd15, 1'b0, 1'b0, 8'h00, 9);
        drain();
        send(8'h01, 4'd7, 1'b1, 1'b0, 8'h80, 8);
        drain();
        send(8'hFF, 4'd8, 1'b0, 1'b0, 8'h00, 9);
        drain();

        // Back-to-back; in_data changes during SHIFT must not matter
        send(8'h80, 4'd1, 1'b0, 1'b0, 8'h40, 2);
        in_data = 8'h00;
        send(8'h3C, 4'd0, 1'b0, 1'b1, 8'h3C, 1);
        send(8'h0F, 4'd4, 1'b1, 1'b1, 8'hFF, 5);
        drain();

        // Backpressure in DONE
        out_ready = 1'b0;
        send(8'hB5, 4'd3, 1'b1, 1'b0, 8'hA8, 4);
        begin
            int t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        held = out_data;
        check("bp_out_valid_start", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_shift = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp_no_extra_accept", 32'(busy), 32'd0);

        // Asynchronous reset during an 8-cycle shift
        send(8'hC3, 4'd8, 1'b1, 1'b0, 8'h00, 9);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h01, 4'd1, 1'b1, 1'b0, 8'h02, 2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
